// File: rtl/redirect_pkg.sv
// redirect_pkg: shared state encoding, reset PC and flush-counter width for the fetch redirect unit
package redirect_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int FLUSH_W = 3;
endpackage

// File: rtl/redirect_flush_counter.sv
// redirect_flush_counter: loadable down-counter timing the extra IF/ID flush cycles after a redirect
module redirect_flush_counter
    import redirect_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FLUSH_W-1:0] load_val,
    input  logic               dec,
    output logic               expiring
);
    logic [FLUSH_W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (dec && count != '0) count <= count - 1'b1;
    end
    // Flags the cycle whose decrement takes the count to zero
    assign expiring = count == FLUSH_W'(1);
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: merges EX redirects, load-use stalls and imem readiness into PC/flush controls
// Optional REDIRECT_COUNT_EN macro enables the applied-redirect counter; otherwise redirectCount is 0.
module fetch_redirect_unit
    import redirect_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exRedirect,
    input  logic [31:0]            exTarget,
    input  logic                   loadUseHazard,
    input  logic                   imemReady,
    output logic                   isStalled,
    output logic                   shouldGoToTarget,
    output logic [31:0]            jumpTarget,
    output logic                   flushIfId,
    output logic                   flushIdEx,
    output logic [COUNT_WIDTH-1:0] redirectCount
);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [1:0] ST_AFTER = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
    logic [1:0] state, state_nxt;
    logic [31:0] pending_target;
    logic capture, expiring;
    always_comb begin
        isStalled = 1'b0;
        shouldGoToTarget = 1'b0;
        jumpTarget = exTarget;
        flushIfId = 1'b0;
        flushIdEx = 1'b0;
        capture = 1'b0;
        state_nxt = state;
        if (rst) begin
            jumpTarget = RESET_PC;
            flushIfId = 1'b1;
            flushIdEx = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exRedirect) begin
                        shouldGoToTarget = imemReady;
                        isStalled = !imemReady;
                        flushIfId = 1'b1;
                        flushIdEx = 1'b1;
                        capture = !imemReady;
                        state_nxt = imemReady ? ST_AFTER : ST_PENDING;
                    end else begin
                        isStalled = loadUseHazard | !imemReady;
                    end
                end
                ST_PENDING: begin
                    // EX holds a bubble here, so any exRedirect is stale and ignored
                    jumpTarget = pending_target;
                    shouldGoToTarget = imemReady;
                    isStalled = !imemReady;
                    flushIfId = imemReady;
                    flushIdEx = 1'b1;
                    state_nxt = imemReady ? ST_AFTER : ST_PENDING;
                end
                ST_FLUSH: begin
                    flushIfId = 1'b1;
                    isStalled = !imemReady;
                    state_nxt = expiring ? ST_IDLE : ST_FLUSH;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pending_target <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (capture) pending_target <= exTarget;
        end
    end
    redirect_flush_counter u_flush (
        .clk      (clk),
        .rst      (rst),
        .load     (shouldGoToTarget),
        .load_val (FLUSH_LOAD),
        .dec      (state == ST_FLUSH),
        .expiring (expiring)
    );
`ifdef REDIRECT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) redirectCount <= '0;
        else if (shouldGoToTarget) redirectCount <= redirectCount + COUNT_WIDTH'(1);
    end
`else
    assign redirectCount = '0;
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed scoreboard bench for fetch_redirect_unit (FLUSH_CYCLES=1 and =3 instances)
module tb_fetch_redirect_unit;
    typedef struct {
        string       tag;
        bit          sel;
        logic [35:0] exp;
        logic [35:0] mask;
        logic [15:0] cnt;
        bit          chk_cnt;
    } exp_t;
    localparam logic [35:0] M_ALL = {36{1'b1}};
    localparam logic [35:0] M_NOJT = {2'b11, 32'h0, 2'b11};
    localparam logic [35:0] M_WAIT = {2'b11, 32'h0, 2'b01};
    logic clk = 1'b0, rst = 1'b1;
    logic ex1 = 0, luh1 = 0, rdy1 = 1, ex3 = 0, luh3 = 0, rdy3 = 1;
    logic [31:0] tgt1 = '0, tgt3 = '0;
    logic st1, sgt1, fif1, fid1, st3, sgt3, fif3, fid3;
    logic [31:0] jt1, jt3;
    logic [1:0] cnt1;
    logic [15:0] cnt3;
    exp_t sb[$];
    int vectors = 0, miscompares = 0, m1 = 0, m3 = 0;
    always #5 clk = ~clk;
    fetch_redirect_unit #(.FLUSH_CYCLES(1), .COUNT_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .exRedirect(ex1), .exTarget(tgt1), .loadUseHazard(luh1),
        .imemReady(rdy1), .isStalled(st1), .shouldGoToTarget(sgt1), .jumpTarget(jt1),
        .flushIfId(fif1), .flushIdEx(fid1), .redirectCount(cnt1)
    );
    fetch_redirect_unit #(.FLUSH_CYCLES(3), .COUNT_WIDTH(16)) u3 (
        .clk(clk), .rst(rst), .exRedirect(ex3), .exTarget(tgt3), .loadUseHazard(luh3),
        .imemReady(rdy3), .isStalled(st3), .shouldGoToTarget(sgt3), .jumpTarget(jt3),
        .flushIfId(fif3), .flushIdEx(fid3), .redirectCount(cnt3)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input string tag, input bit sel, input bit st, input bit sgt,
                        input logic [31:0] jt, input bit fif, input bit fid,
                        input logic [35:0] mask, input bit chk_cnt);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = {st, sgt, jt, fif, fid};
        e.mask = mask;
`ifdef REDIRECT_COUNT_EN
        e.cnt = sel ? 16'(m3) : 16'(m1 % 4);
`else
        e.cnt = '0;
`endif
        e.chk_cnt = chk_cnt;
        sb.push_back(e);
        if (sgt && sel) m3++;
        if (sgt && !sel) m1++;
    endtask
    task automatic chk();
        exp_t e;
        logic [35:0] obs;
        logic [15:0] cobs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.sel ? {st3, sgt3, jt3, fif3, fid3} : {st1, sgt1, jt1, fif1, fid1};
            cobs = e.sel ? cnt3 : {14'h0, cnt1};
            vectors++;
            assert ((obs & e.mask) === (e.exp & e.mask)) else begin
                miscompares++;
                $error("FAIL %s outs {stall,go,target,flushIfId,flushIdEx} observed=%h expected=%h mask=%h",
                       e.tag, obs, e.exp, e.mask);
            end
            if (e.chk_cnt) begin
                vectors++;
                assert (cobs === e.cnt) else begin
                    miscompares++;
                    $error("FAIL %s_count observed=%0d expected=%0d", e.tag, cobs, e.cnt);
                end
            end
        end
    endtask
    initial begin
        rst = 1; ex1 = 0; rdy1 = 1;
        push("reset", 0, 0, 0, 32'h0, 1, 1, M_ALL, 0);
        chk();
        m1 = 0; m3 = 0;
        tick(); rst = 0;
        push("idle", 0, 0, 0, 32'h0, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; tgt1 = 32'h40;
        push("redir40", 0, 0, 1, 32'h40, 1, 1, M_ALL, 1);
        chk();
        tick(); ex1 = 0;
        push("after40", 0, 0, 0, 32'h40, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; tgt1 = 32'h80; rdy1 = 0;
        push("capture80", 0, 1, 0, 32'h0, 1, 1, M_NOJT, 1);
        chk();
        tick(); tgt1 = 32'hC0;
        push("pend_w1", 0, 1, 0, 32'h0, 0, 1, M_WAIT, 1);
        chk();
        tick();
        push("pend_w2", 0, 1, 0, 32'h0, 0, 1, M_WAIT, 1);
        chk();
        tick(); rdy1 = 1;
        push("replay80", 0, 0, 1, 32'h80, 1, 1, M_ALL, 1);
        chk();
        tick(); ex1 = 0; tgt1 = 32'h0;
        push("no_c0", 0, 0, 0, 32'h0, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; luh1 = 1; tgt1 = 32'h200;
        push("luh_redir", 0, 0, 1, 32'h200, 1, 1, M_ALL, 1);
        chk();
        tick(); ex1 = 0;
        push("luh_only", 0, 1, 0, 32'h200, 0, 0, M_ALL, 1);
        chk();
        tick(); luh1 = 0; rdy1 = 0;
        push("imem_busy", 0, 1, 0, 32'h200, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; rdy1 = 1; tgt1 = 32'h300;
        push("redir4", 0, 0, 1, 32'h300, 1, 1, M_ALL, 1);
        chk();
        tick(); ex1 = 0;
        push("idle4", 0, 0, 0, 32'h300, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; tgt1 = 32'h304;
        push("redir5", 0, 0, 1, 32'h304, 1, 1, M_ALL, 1);
        chk();
        tick(); ex1 = 0;
        push("wrap", 0, 0, 0, 32'h304, 0, 0, M_ALL, 1);
        chk();
        tick(); ex1 = 1; rdy1 = 0; tgt1 = 32'h500;
        push("capture500", 0, 1, 0, 32'h0, 1, 1, M_NOJT, 1);
        chk();
        tick(); ex1 = 0;
        push("pend500", 0, 1, 0, 32'h0, 0, 1, M_WAIT, 1);
        chk();
        tick(); rst = 1; rdy1 = 1; tgt1 = 32'h0;
        push("mid_rst", 0, 0, 0, 32'h0, 1, 1, M_ALL, 0);
        chk();
        m1 = 0; m3 = 0;
        tick(); rst = 0;
        push("no_replay", 0, 0, 0, 32'h0, 0, 0, M_ALL, 1);
        chk();
        tick(); ex3 = 1; tgt3 = 32'h100;
        push("f3_redir", 1, 0, 1, 32'h100, 1, 1, M_ALL, 1);
        chk();
        tick(); tgt3 = 32'h300;
        push("f3_flush1", 1, 0, 0, 32'h0, 1, 0, M_NOJT, 1);
        chk();
        tick(); rdy3 = 0;
        push("f3_flush2", 1, 1, 0, 32'h0, 1, 0, M_NOJT, 1);
        chk();
        tick(); ex3 = 0; rdy3 = 1;
        push("f3_idle", 1, 0, 0, 32'h300, 0, 0, M_ALL, 1);
        chk();
        tick(); ex3 = 1; tgt3 = 32'h400;
        push("f3_redir2", 1, 0, 1, 32'h400, 1, 1, M_ALL, 1);
        chk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
